stopwatch_ctrl: RTL and testbench
=================================

# stopwatch_ctrl

Stopwatch controller that sequences the MM:SS BCD time counter from the divided-clock tick strobe. It runs the start/pause/lap/clear state machine driven by pre-debounced button pulses and presents four BCD digits to the seven-segment display path. It sits between the clock-divider tick outputs and the display scanner.

## Interface
- TICKS_PER_SEC, default 1: tick pulses per counted second; 1 for a 1 Hz strobe, 100 for a 100 Hz strobe. Legal range 1..1023.
- clk_tmp1  input  1  block clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- tick  input  1  one-cycle count-enable strobe, synchronous to clk_tmp1.
- start_stop  input  1  one-cycle debounced button pulse.
- lap_reset  input  1  one-cycle debounced button pulse.
- disp_min_tens  output  4  displayed BCD digit, 0..5.
- disp_min_ones  output  4  displayed BCD digit, 0..9.
- disp_sec_tens  output  4  displayed BCD digit, 0..5.
- disp_sec_ones  output  4  displayed BCD digit, 0..9.
- running  output  1  high in RUN and LAP.
- lap_frozen  output  1  high in LAP.
- wrap  output  1  one-cycle pulse when the live count rolls 59:59 -> 00:00.

## Operation
- States: IDLE, RUN, PAUSE, LAP. Reset state is IDLE.
- IDLE: start_stop -> RUN. lap_reset is ignored.
- RUN: start_stop -> PAUSE. lap_reset -> LAP, which captures the live count into the lap register.
- LAP: start_stop -> PAUSE and releases the freeze. lap_reset -> RUN and releases the freeze.
- PAUSE: start_stop -> RUN. lap_reset -> IDLE and clears the live count and prescaler to 0.
- If start_stop and lap_reset arrive in the same cycle, start_stop wins and lap_reset is dropped.
- Prescaler:
  - Counts tick pulses only while the current (registered) state is RUN or LAP.
  - At TICKS_PER_SEC-1 plus a tick, it returns to 0 and advances the live count one second.
  - It holds its value in PAUSE, so a partial second is kept across pause and resume.
- Live count is cascaded BCD: sec_ones 9->0 carries to sec_tens; sec_tens 5->0 carries to min_ones; min_ones 9->0 carries to min_tens; min_tens 5->0 ends the rollover.
- The full rollover 59:59 -> 00:00 asserts wrap for exactly one cycle, and counting continues.
- Display mux: the disp_* outputs show the lap register in LAP and the live count in every other state.
- Counting continues underneath while in LAP.

## Timing
- Reset values:
  - All disp_* = 0; running = 0; lap_frozen = 0; wrap = 0.
  - State = IDLE; prescaler, live count and lap register = 0.
- A button pulse sampled at edge N changes the state at edge N; running and lap_frozen reflect it after edge N.
- The count decision uses the pre-edge state:
  - A tick in the same cycle as the IDLE->RUN start_stop is not counted.
  - A tick in the same cycle as the RUN->PAUSE start_stop is counted.
- Lap capture happens at the RUN->LAP edge and takes the post-increment count if a second completes at that edge.
- The display changes after the same edge that updates the live count. Zero added latency; the mux is combinational from registers.
- Clear at PAUSE->IDLE takes effect at that edge. wrap is never asserted by a clear.
- Asserting reset mid-count forces all reset values immediately, with no waiting for a clock edge.

## Configuration
- STOPWATCH_LAP_EN defined: full behaviour as above.
- STOPWATCH_LAP_EN undefined:
  - LAP state, lap register and mux are removed, and lap_frozen is tied to 0.
  - lap_reset in RUN is ignored; lap_reset still clears from PAUSE.

## Structure
- Package stopwatch_pkg holds:
  - the state enum (IDLE, RUN, PAUSE, LAP);
  - digit limit constants SEC_ONES_MAX=9, SEC_TENS_MAX=5, MIN_ONES_MAX=9, MIN_TENS_MAX=5;
  - the 4-bit BCD digit typedef.
- One sub-module, bcd_digit_counter:
  - parameter MAX; inputs clk_tmp1, rst_n, clr, inc; outputs digit, carry.
  - carry = inc && digit==MAX.
  - Instantiated four times in a carry chain.

## Test plan
- Reset, TICKS_PER_SEC=1: start_stop, then 75 ticks -> disp 01:15, running=1; the tick coincident with start_stop is not counted.
- TICKS_PER_SEC=100: start_stop, 250 ticks, start_stop, 50 ticks, start_stop, 50 ticks -> disp 00:03 (pause holds the prescaler; ticks in PAUSE are ignored).
- Preload to 59:58, 2 seconds of ticks -> disp 00:00 and wrap high exactly one cycle at the 59:59->00:00 edge.
- RUN at 00:10, lap_reset -> lap_frozen=1 and disp stays 00:10 through 5 ticks; lap_reset -> disp 00:15 and lap_frozen=0.
- start_stop and lap_reset in the same cycle while in RUN -> PAUSE, no lap capture. Then lap_reset -> IDLE with disp 00:00.
- Assert rst_n low mid-count at 12:34 -> all outputs 0 immediately; after release, state is IDLE and ticks do not count.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types, digit limits and the BCD increment helper for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t SEC_ONES_MAX = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t MIN_ONES_MAX = 4'd9;
  localparam bcd_t MIN_TENS_MAX = 4'd5;

  // Prescaler width covers TICKS_PER_SEC up to 1023.
  localparam int PRE_W = 10;

  function automatic bcd_t bcd_next(input bcd_t d, input bcd_t max, input logic inc);
    bcd_t r;
    if (!inc) begin
      r = d;
    end else if (d == max) begin
      r = 4'd0;
    end else begin
      r = d + 4'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit_counter.sv
// One BCD digit of the live count; wraps at MAX and reports a carry to the next digit.
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = SEC_ONES_MAX
) (
  input  logic clk_tmp1,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output bcd_t digit,
  output logic carry
);

  // Digit register: clear has priority over increment.
  always_ff @(posedge clk_tmp1 or negedge rst_n) begin
    if (!rst_n) begin
      digit <= 4'd0;
    end else if (clr) begin
      digit <= 4'd0;
    end else begin
      digit <= bcd_next(digit, MAX, inc);
    end
  end

  assign carry = inc && (digit == MAX);

endmodule

// File: rtl/stopwatch_ctrl.sv
// MM:SS stopwatch controller: start/pause/lap/clear FSM, tick prescaler and BCD display mux.
// Define STOPWATCH_LAP_EN to build the LAP state, lap register and display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICKS_PER_SEC = 1
) (
  input  logic       clk_tmp1,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       lap_reset,
  output logic [3:0] disp_min_tens,
  output logic [3:0] disp_min_ones,
  output logic [3:0] disp_sec_tens,
  output logic [3:0] disp_sec_ones,
  output logic       running,
  output logic       lap_frozen,
  output logic       wrap
);

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_SEC - 1);

  sw_state_t        state_r, next_state_s;
  logic [PRE_W-1:0] pre_r;
  logic             count_en_s, sec_inc_s, clr_s;
  logic             running_r, wrap_r;
  bcd_t             so_s, st_s, mo_s, mt_s;
  logic             so_c_s, st_c_s, mo_c_s, mt_c_s;
  logic [15:0]      live_s, disp_s;

  // Counting is decided by the pre-edge state, so the start edge itself never counts.
  assign count_en_s = tick && ((state_r == RUN) || (state_r == LAP));
  assign sec_inc_s  = count_en_s && (pre_r == PRE_LAST);

  // Next-state decode; start_stop always outranks lap_reset.
  always_comb begin
    next_state_s = state_r;
    clr_s        = 1'b0;
    case (state_r)
      IDLE: begin
        if (start_stop) next_state_s = RUN;
        else            next_state_s = IDLE;
      end
      RUN: begin
        if (start_stop) next_state_s = PAUSE;
`ifdef STOPWATCH_LAP_EN
        else if (lap_reset) next_state_s = LAP;
`endif
        else next_state_s = RUN;
      end
      LAP: begin
        if (start_stop)     next_state_s = PAUSE;
        else if (lap_reset) next_state_s = RUN;
        else                next_state_s = LAP;
      end
      PAUSE: begin
        if (start_stop) begin
          next_state_s = RUN;
        end else if (lap_reset) begin
          next_state_s = IDLE;
          clr_s        = 1'b1;
        end else begin
          next_state_s = PAUSE;
        end
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State and registered status flags.
  always_ff @(posedge clk_tmp1 or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      running_r <= 1'b0;
      wrap_r    <= 1'b0;
    end else begin
      state_r   <= next_state_s;
      running_r <= (next_state_s == RUN) || (next_state_s == LAP);
      wrap_r    <= mt_c_s;
    end
  end

  // Prescaler: holds outside RUN/LAP so a partial second survives a pause.
  always_ff @(posedge clk_tmp1 or negedge rst_n) begin
    if (!rst_n) begin
      pre_r <= '0;
    end else if (clr_s || sec_inc_s) begin
      pre_r <= '0;
    end else if (count_en_s) begin
      pre_r <= pre_r + PRE_W'(1);
    end else begin
      pre_r <= pre_r;
    end
  end

  bcd_digit_counter #(.MAX(SEC_ONES_MAX)) u_sec_ones (
    .clk_tmp1(clk_tmp1), .rst_n(rst_n), .clr(clr_s), .inc(sec_inc_s), .digit(so_s), .carry(so_c_s)
  );
  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk_tmp1(clk_tmp1), .rst_n(rst_n), .clr(clr_s), .inc(so_c_s), .digit(st_s), .carry(st_c_s)
  );
  bcd_digit_counter #(.MAX(MIN_ONES_MAX)) u_min_ones (
    .clk_tmp1(clk_tmp1), .rst_n(rst_n), .clr(clr_s), .inc(st_c_s), .digit(mo_s), .carry(mo_c_s)
  );
  bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
    .clk_tmp1(clk_tmp1), .rst_n(rst_n), .clr(clr_s), .inc(mo_c_s), .digit(mt_s), .carry(mt_c_s)
  );

  assign live_s = {mt_s, mo_s, st_s, so_s};

`ifdef STOPWATCH_LAP_EN
  logic        lap_cap_s, lap_frozen_r;
  logic [15:0] lap_r, live_next_s;

  assign lap_cap_s   = (state_r == RUN) && lap_reset && !start_stop;
  // Capture sees the count as it will be after this edge, including a completing second.
  assign live_next_s = {bcd_next(mt_s, MIN_TENS_MAX, mo_c_s),
                        bcd_next(mo_s, MIN_ONES_MAX, st_c_s),
                        bcd_next(st_s, SEC_TENS_MAX, so_c_s),
                        bcd_next(so_s, SEC_ONES_MAX, sec_inc_s)};

  // Lap register and freeze flag.
  always_ff @(posedge clk_tmp1 or negedge rst_n) begin
    if (!rst_n) begin
      lap_r        <= 16'd0;
      lap_frozen_r <= 1'b0;
    end else begin
      lap_frozen_r <= (next_state_s == LAP);
      if (lap_cap_s) lap_r <= live_next_s;
      else           lap_r <= lap_r;
    end
  end

  // Display mux: frozen lap value only while in LAP.
  always_comb begin
    disp_s = live_s;
    if (state_r == LAP) disp_s = lap_r;
    else                disp_s = live_s;
  end

  assign lap_frozen = lap_frozen_r;
`else
  assign disp_s     = live_s;
  assign lap_frozen = 1'b0;
`endif

  assign {disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones} = disp_s;
  assign running = running_r;
  assign wrap    = wrap_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: seconds-based reference model, per-cycle expected queue.
module tb_stopwatch_ctrl;

  localparam int TPS = 4;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk_tmp1 = 1'b0;
  logic       rst_n, tick, start_stop, lap_reset;
  logic [3:0] disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones;
  logic       running, lap_frozen, wrap;

  stopwatch_ctrl #(.TICKS_PER_SEC(TPS)) dut (
    .clk_tmp1(clk_tmp1), .rst_n(rst_n), .tick(tick), .start_stop(start_stop),
    .lap_reset(lap_reset), .disp_min_tens(disp_min_tens), .disp_min_ones(disp_min_ones),
    .disp_sec_tens(disp_sec_tens), .disp_sec_ones(disp_sec_ones), .running(running),
    .lap_frozen(lap_frozen), .wrap(wrap)
  );

  always #5 clk_tmp1 = ~clk_tmp1;

  typedef struct packed {
    logic [15:0] disp;
    logic        run;
    logic        lapf;
    logic        wrp;
  } obs_t;

  obs_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   wrap_seen = 0;

  // Reference model: time kept as plain seconds 0..3599.
  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_LAP} mstate_t;
  mstate_t m_st;
  int      m_sec, m_pre, m_lap;
  bit      m_wrap;

  function automatic logic [15:0] to_bcd(input int s);
    logic [15:0] r;
    r = {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
    return r;
  endfunction

  function automatic void model_reset();
    m_st = M_IDLE; m_sec = 0; m_pre = 0; m_lap = 0; m_wrap = 1'b0;
  endfunction

  function automatic void model_step(input bit ss, input bit lr, input bit tk);
    m_wrap = 1'b0;
    if ((m_st == M_RUN || m_st == M_LAP) && tk) begin
      m_pre = m_pre + 1;
      if (m_pre == TPS) begin
        m_pre = 0;
        if (m_sec == 3599) begin m_sec = 0; m_wrap = 1'b1; end
        else m_sec = m_sec + 1;
      end
    end
    case (m_st)
      M_IDLE:  if (ss) m_st = M_RUN;
      M_RUN:   if (ss) m_st = M_PAUSE;
               else if (lr && LAP_EN) begin m_st = M_LAP; m_lap = m_sec; end
      M_LAP:   if (ss) m_st = M_PAUSE; else if (lr) m_st = M_RUN;
      M_PAUSE: if (ss) m_st = M_RUN;
               else if (lr) begin m_st = M_IDLE; m_sec = 0; m_pre = 0; end
      default: m_st = M_IDLE;
    endcase
  endfunction

  function automatic obs_t model_obs();
    obs_t o;
    o.disp = (m_st == M_LAP) ? to_bcd(m_lap) : to_bcd(m_sec);
    o.run  = (m_st == M_RUN) || (m_st == M_LAP);
    o.lapf = (m_st == M_LAP);
    o.wrp  = m_wrap;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    obs_t o;
    o = {disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones, running, lap_frozen, wrap};
    return o;
  endfunction

  task automatic cycle(input bit ss, input bit lr, input bit tk);
    @(negedge clk_tmp1);
    start_stop = ss; lap_reset = lr; tick = tk;
    model_step(ss, lr, tk);
    exp_q.push_back(model_obs());
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1);
  endtask

  task automatic expect_now(input string name, input logic [15:0] ed, input bit er, input bit el);
    cycle(1'b0, 1'b0, 1'b0);
    @(posedge clk_tmp1);
    #2;
    checks++;
    if ({disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones} !== ed ||
        running !== er || lap_frozen !== el) begin
      errors++;
      $display("FAIL %s: got disp=%h run=%b lapf=%b, want disp=%h run=%b lapf=%b", name,
               {disp_min_tens, disp_min_ones, disp_sec_tens, disp_sec_ones}, running,
               lap_frozen, ed, er, el);
    end
  endtask

  task automatic expect_zero(input string name);
    checks++;
    if (dut_obs() !== '0) begin
      errors++;
      $display("FAIL %s: got outputs=%h, want 0", name, dut_obs());
    end
  endtask

  task automatic drive_to_idle();
    while (m_st != M_IDLE) begin
      if (m_st == M_PAUSE) cycle(1'b0, 1'b1, 1'b0);
      else                 cycle(1'b1, 1'b0, 1'b0);
    end
  endtask

  // Monitor: one comparison per expected entry, sampled just after the active edge.
  initial begin
    obs_t e, a;
    forever begin
      @(posedge clk_tmp1);
      #1;
      if (wrap === 1'b1) wrap_seen++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_obs();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got disp=%h run=%b lapf=%b wrap=%b, want disp=%h run=%b lapf=%b wrap=%b",
                   $time, a.disp, a.run, a.lapf, a.wrp, e.disp, e.run, e.lapf, e.wrp);
        end
      end
    end
  end

  initial begin
    int w0;
    rst_n = 1'b0; tick = 1'b0; start_stop = 1'b0; lap_reset = 1'b0;
    model_reset();
    #1;
    expect_zero("reset_state");
    @(negedge clk_tmp1);
    rst_n = 1'b1;

    // lap_reset ignored in IDLE; the start tick is not counted
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1);
    expect_now("idle_ignore", 16'h0000, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b1);
    ticks(75 * TPS);
    expect_now("count_01_15", 16'h0115, 1'b1, 1'b0);

    // pause keeps the partial second; ticks in PAUSE are ignored
    drive_to_idle();
    expect_now("clear_idle", 16'h0000, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 1'b0);
    ticks(10);
    cycle(1'b1, 1'b0, 1'b0);
    ticks(6);
    cycle(1'b1, 1'b0, 1'b0);
    ticks(2);
    expect_now("prescaler_hold", 16'h0003, 1'b1, 1'b0);

    // lap freeze and release
    drive_to_idle();
    cycle(1'b1, 1'b0, 1'b0);
    ticks(10 * TPS);
    cycle(1'b0, 1'b1, 1'b0);
    expect_now("lap_enter", 16'h0010, 1'b1, LAP_EN);
    ticks(5 * TPS);
    expect_now("lap_hold", LAP_EN ? 16'h0010 : 16'h0015, 1'b1, LAP_EN);
    cycle(1'b0, 1'b1, 1'b0);
    expect_now("lap_release", 16'h0015, 1'b1, 1'b0);

    // start_stop beats lap_reset, then clear from PAUSE
    cycle(1'b1, 1'b1, 1'b0);
    expect_now("ss_wins", 16'h0015, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0);
    expect_now("pause_clear", 16'h0000, 1'b0, 1'b0);

    // randomized button/tick traffic
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(19, 0) == 0, $urandom_range(19, 0) == 0, $urandom_range(1, 0) == 1);

    // full rollover
    drive_to_idle();
    cycle(1'b1, 1'b0, 1'b0);
    ticks(3598 * TPS);
    expect_now("at_59_58", 16'h5958, 1'b1, 1'b0);
    w0 = wrap_seen;
    ticks(2 * TPS);
    expect_now("after_wrap", 16'h0000, 1'b1, 1'b0);
    checks++;
    if (wrap_seen - w0 != 1) begin
      errors++;
      $display("FAIL wrap_count: got %0d pulses, want 1", wrap_seen - w0);
    end

    // asynchronous reset mid-count
    ticks(754 * TPS);
    expect_now("at_12_34", 16'h1234, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    expect_zero("async_reset");
    model_reset();
    ticks(3);
    rst_n = 1'b1;
    ticks(4 * TPS);
    expect_now("post_reset_idle", 16'h0000, 1'b0, 1'b0);

    @(posedge clk_tmp1);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
